// File: rtl/tc_acquire_arbiter.sv
// Round-robin arbiter sharing one TileLink acquire port among NREQ requesters,
// with burst locking, per-requester outstanding limits and index-routed grants.
module tc_acquire_arbiter #(
   parameter int NREQ   = 4,
   parameter int IDXW   = 2,
   parameter int XIDW   = 5,
   parameter int PW     = 120,
   parameter int GW     = 90,
   parameter int MAXOUT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_multibeat,
   input  logic [NREQ*PW-1:0]     req_bits,
   output logic                   acq_valid,
   input  logic                   acq_ready,
   output logic [PW+IDXW-1:0]     acq_bits,
   input  logic                   gnt_valid,
   output logic                   gnt_ready,
   input  logic                   gnt_last,
   input  logic [GW-1:0]          gnt_bits,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [GW-IDXW-1:0]     rsp_bits
);

   // Fields below xact_id: beat[3], a_type[3], union[13], data[64], tag[1]
   localparam int XLSB = 84;
   localparam int CW   = 3;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t            state, state_nxt;
   logic [IDXW-1:0]   rr_ptr, rr_nxt;
   logic [IDXW-1:0]   owner, owner_nxt;
   logic [2:0]        beat, beat_nxt;
   logic [CW-1:0]     cnt [NREQ];

   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   inc, dec;
   logic [IDXW-1:0]   winner, cand, gidx;
   logic              any_elig, acq_fire, gnt_fire;
   logic [PW-1:0]     win_bits;

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++)
         eligible[i] = req_valid[i] && ((cnt[i] < CW'(MAXOUT)) || (state == LOCK));
   end

   always_comb begin
      winner   = '0;
      any_elig = 1'b0;
      cand     = '0;
      if (state == LOCK) begin
         winner   = owner;
         any_elig = req_valid[owner];
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            cand = rr_ptr + IDXW'(k);
            if (!any_elig && eligible[cand]) begin
               winner   = cand;
               any_elig = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win_bits  = req_bits[int'(winner)*PW +: PW];
      acq_valid = !reset && any_elig;
      acq_bits  = {win_bits[PW-1:XLSB+XIDW], winner, win_bits[XLSB+XIDW-1:0]};
      req_ready = '0;
      if (acq_valid)
         req_ready[winner] = acq_ready;
      acq_fire  = acq_valid && acq_ready;
   end

   always_comb begin
      gidx      = gnt_bits[GW-1 -: IDXW];
      rsp_bits  = gnt_bits[GW-IDXW-1:0];
      rsp_valid = (!reset && gnt_valid) ? (NREQ'(1) << gidx) : '0;
      gnt_ready = !reset && rsp_ready[gidx];
      gnt_fire  = gnt_valid && gnt_ready;
      dec       = (gnt_fire && gnt_last) ? (NREQ'(1) << gidx) : '0;
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      beat_nxt  = beat;
      rr_nxt    = rr_ptr;
      inc       = '0;
      case (state)
         IDLE: begin
            if (acq_fire) begin
               inc[winner] = 1'b1;
               rr_nxt      = winner + IDXW'(1);
               if (req_multibeat[winner]) begin
                  state_nxt = LOCK;
                  owner_nxt = winner;
                  beat_nxt  = 3'd1;
               end
            end
         end
         LOCK: begin
            if (acq_fire) begin
               beat_nxt = beat + 3'd1;
               if (beat == 3'd7)
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         beat   <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_nxt;
         owner  <= owner_nxt;
         beat   <= beat_nxt;
      end
   end

   // Same-cycle inc and dec cancel; out-of-range moves saturate instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREQ; i++)
            cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (inc[i] && !dec[i] && (cnt[i] < CW'(MAXOUT)))
               cnt[i] <= cnt[i] + CW'(1);
            else if (dec[i] && !inc[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - CW'(1);
         end
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_cnt_chk
      a_no_overflow  : assert property (@(posedge clk) disable iff (reset)
                          !(inc[g] && !dec[g] && (cnt[g] >= CW'(MAXOUT))));
      a_no_underflow : assert property (@(posedge clk) disable iff (reset)
                          !(dec[g] && !inc[g] && (cnt[g] == '0)));
   end

endmodule

// File: tb/tb_tc_acquire_arbiter.sv
// Directed bench for tc_acquire_arbiter: reset, round robin, burst lock,
// throttling, grant routing, same-cycle inc/dec and reset mid-burst.
module tb_tc_acquire_arbiter;

   localparam int NREQ = 4;
   localparam int IDXW = 2;
   localparam int XIDW = 5;
   localparam int PW   = 120;
   localparam int GW   = 90;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_multibeat;
   logic [NREQ*PW-1:0]   req_bits;
   logic                 acq_valid;
   logic                 acq_ready;
   logic [PW+IDXW-1:0]   acq_bits;
   logic                 gnt_valid;
   logic                 gnt_ready;
   logic                 gnt_last;
   logic [GW-1:0]        gnt_bits;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [GW-IDXW-1:0]   rsp_bits;

   int unsigned errors = 0;
   int unsigned checks = 0;

   tc_acquire_arbiter #(
      .NREQ(NREQ), .IDXW(IDXW), .XIDW(XIDW), .PW(PW), .GW(GW), .MAXOUT(2)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_multibeat(req_multibeat), .req_bits(req_bits),
      .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_bits(acq_bits),
      .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_last(gnt_last),
      .gnt_bits(gnt_bits),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bits(rsp_bits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [83:0] low_of(int unsigned i);
      return {3'(i), 3'd2, 13'(i + 5), 64'hC0DE_0000_0000_0000 | 64'(i), 1'b1};
   endfunction

   function automatic logic [PW-1:0] mk_req(int unsigned i);
      return {31'h1000 + 31'(i), 5'(3*i + 1), low_of(i)};
   endfunction

   function automatic logic [PW+IDXW-1:0] mk_acq(int unsigned i);
      return {31'h1000 + 31'(i), 2'(i), 5'(3*i + 1), low_of(i)};
   endfunction

   localparam logic [82:0] GPAY = 83'(64'h1234_5678_9ABC_DEF0);

   function automatic logic [GW-1:0] mk_gnt(int unsigned idx, int unsigned xid);
      return {2'(idx), 5'(xid), GPAY};
   endfunction

   function automatic logic [3:0] oh(int unsigned i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = '0;
      req_multibeat = '0;
      acq_ready     = 1'b1;
      gnt_valid     = 1'b0;
      gnt_last      = 1'b0;
      gnt_bits      = '0;
      rsp_ready     = '1;
   endtask

   task automatic grant(input int unsigned idx, input string tag);
      gnt_valid = 1'b1;
      gnt_last  = 1'b1;
      gnt_bits  = mk_gnt(idx, 3);
      #1;
      chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(oh(idx)));
      chk({tag, "_gnt_ready"}, 128'(gnt_ready), 128'(1'b1));
      step();
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
   endtask

   initial begin
      for (int unsigned i = 0; i < NREQ; i++)
         req_bits[i*PW +: PW] = mk_req(i);

      // 1. reset with everything requesting
      idle_inputs();
      reset     = 1'b1;
      req_valid = '1;
      gnt_valid = 1'b1;
      gnt_bits  = mk_gnt(0, 1);
      #1;
      chk("rst_acq_valid", 128'(acq_valid), 128'(1'b0));
      chk("rst_req_ready", 128'(req_ready), 128'(4'b0000));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(4'b0000));
      chk("rst_gnt_ready", 128'(gnt_ready), 128'(1'b0));
      step();
      step();
      idle_inputs();
      reset = 1'b0;
      #1;
      chk("post_rst_idle", 128'(acq_valid), 128'(1'b0));
      step();

      // 2. round robin with grants returned one cycle later
      for (int unsigned c = 0; c < 5; c++) begin
         req_valid = '1;
         if (c > 0) begin
            gnt_valid = 1'b1;
            gnt_last  = 1'b1;
            gnt_bits  = mk_gnt((c - 1) % 4, 2);
         end
         #1;
         chk("rr_acq_valid", 128'(acq_valid), 128'(1'b1));
         chk("rr_req_ready", 128'(req_ready), 128'(oh(c % 4)));
         chk("rr_acq_bits", 128'(acq_bits), 128'(mk_acq(c % 4)));
         if (c > 0) begin
            chk("rr_rsp_valid", 128'(rsp_valid), 128'(oh((c - 1) % 4)));
            chk("rr_gnt_ready", 128'(gnt_ready), 128'(1'b1));
         end
         step();
      end
      req_valid = '0;
      grant(0, "rr_drain0");

      // 3. burst lock: req1 owns 8 beats, gaps do not let others in
      req_valid     = 4'b0111;
      req_multibeat = 4'b0010;
      for (int unsigned b = 0; b < 8; b++) begin
         if (b == 4) begin
            for (int unsigned g = 0; g < 2; g++) begin
               req_valid = 4'b0101;
               #1;
               chk("lock_gap_acq_valid", 128'(acq_valid), 128'(1'b0));
               chk("lock_gap_req_ready", 128'(req_ready), 128'(4'b0000));
               step();
            end
            req_valid = 4'b0111;
         end
         #1;
         chk("lock_acq_valid", 128'(acq_valid), 128'(1'b1));
         chk("lock_req_ready", 128'(req_ready), 128'(4'b0010));
         chk("lock_acq_bits", 128'(acq_bits), 128'(mk_acq(1)));
         step();
      end
      req_multibeat = '0;
      req_valid     = 4'b0111;
      #1;
      chk("after_lock_winner", 128'(req_ready), 128'(4'b0100));
      step();
      req_valid = '0;
      grant(1, "lock_drain1");
      grant(2, "lock_drain2");

      // 4. throttle req3 at two outstanding
      req_valid = 4'b1000;
      #1;
      chk("thr_first", 128'(req_ready), 128'(4'b1000));
      step();
      #1;
      chk("thr_second", 128'(req_ready), 128'(4'b1000));
      step();
      #1;
      chk("thr_blocked_valid", 128'(acq_valid), 128'(1'b0));
      chk("thr_blocked_ready", 128'(req_ready), 128'(4'b0000));
      step();
      req_valid = 4'b1010;
      #1;
      chk("thr_other_a", 128'(req_ready), 128'(4'b0010));
      step();
      #1;
      chk("thr_other_b", 128'(req_ready), 128'(4'b0010));
      step();
      req_valid = 4'b1000;
      gnt_valid = 1'b1;
      gnt_last  = 1'b1;
      gnt_bits  = mk_gnt(3, 9);
      #1;
      chk("thr_still_blocked", 128'(acq_valid), 128'(1'b0));
      chk("thr_gnt_rsp_valid", 128'(rsp_valid), 128'(4'b1000));
      chk("thr_gnt_ready", 128'(gnt_ready), 128'(1'b1));
      step();
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      #1;
      chk("thr_released_valid", 128'(acq_valid), 128'(1'b1));
      chk("thr_released_ready", 128'(req_ready), 128'(4'b1000));
      step();
      req_valid = '0;
      grant(3, "thr_drain3a");
      grant(3, "thr_drain3b");
      grant(1, "thr_drain1a");
      grant(1, "thr_drain1b");

      // 5. grant routing with back-pressure from requester 2
      gnt_valid = 1'b1;
      gnt_last  = 1'b0;
      gnt_bits  = {7'b10_00101, GPAY};
      rsp_ready = 4'b1011;
      for (int unsigned c = 0; c < 3; c++) begin
         #1;
         chk("route_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
         chk("route_gnt_ready", 128'(gnt_ready), 128'(1'b0));
         step();
      end
      rsp_ready = '1;
      #1;
      chk("route_fire_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
      chk("route_fire_gnt_ready", 128'(gnt_ready), 128'(1'b1));
      chk("route_rsp_bits", 128'(rsp_bits), 128'({5'b00101, GPAY}));
      step();
      gnt_valid = 1'b0;

      // 6. same-cycle inc and dec of cnt[0] leaves it at 1
      req_valid = 4'b0001;
      #1;
      chk("same_s1", 128'(req_ready), 128'(4'b0001));
      step();
      gnt_valid = 1'b1;
      gnt_last  = 1'b1;
      gnt_bits  = mk_gnt(0, 4);
      #1;
      chk("same_s2_req", 128'(req_ready), 128'(4'b0001));
      chk("same_s2_gnt", 128'(gnt_ready), 128'(1'b1));
      step();
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      #1;
      chk("same_s3_eligible", 128'(acq_valid), 128'(1'b1));
      step();
      #1;
      chk("same_s4_blocked", 128'(acq_valid), 128'(1'b0));
      step();

      // 7. reset in the middle of a burst clears lock and counters
      req_valid     = 4'b0010;
      req_multibeat = 4'b0010;
      for (int unsigned b = 0; b < 2; b++) begin
         #1;
         chk("rstb_beat", 128'(req_ready), 128'(4'b0010));
         step();
      end
      reset = 1'b1;
      #1;
      chk("rstb_acq_valid", 128'(acq_valid), 128'(1'b0));
      chk("rstb_req_ready", 128'(req_ready), 128'(4'b0000));
      step();
      reset         = 1'b0;
      req_valid     = 4'b0101;
      req_multibeat = '0;
      #1;
      chk("rstb_after_valid", 128'(acq_valid), 128'(1'b1));
      chk("rstb_after_ready", 128'(req_ready), 128'(4'b0001));
      acq_ready = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
